// File: rtl/ctrl_sd_alt_checker.sv
// ctrl_sd_alt_checker
//   Alternating-logic sequencer and checker for a self-dualized combinational
//   netlist. Every accepted vector is applied twice: first true (phase A),
//   then bitwise complemented (phase B). Each output bit must invert between
//   the two phases. The block returns the phase-A output word, a per-bit
//   violation mask and an error flag. It also keeps a sticky error flag and a
//   saturating error counter.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   in_valid_i    request vector valid
//   in_ready_o    block can accept a vector (IDLE only)
//   in_vec_i      vector to check
//   dut_x_o       registered drive to the netlist inputs
//   dut_y_i       netlist outputs, combinational from dut_x_o
//   out_valid_o   result valid (DONE)
//   out_ready_i   consumer accepts result
//   out_y_o       netlist output sampled in phase A
//   out_mask_o    1 where phase-A and phase-B bits are equal
//   out_err_o     OR-reduction of out_mask_o
//   err_sticky_o  set by any erroring result, cleared by reset or err_clr_i
//   err_cnt_o     count of erroring results, saturating at all-ones
//   err_clr_i     synchronous clear of err_cnt_o and err_sticky_o
module ctrl_sd_alt_checker #(
    parameter int W_IN   = 33,
    parameter int W_OUT  = 26,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W_IN-1:0]  in_vec_i,
    output logic [W_IN-1:0]  dut_x_o,
    input  logic [W_OUT-1:0] dut_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OUT-1:0] out_y_o,
    output logic [W_OUT-1:0] out_mask_o,
    output logic             out_err_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             err_clr_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PH_A = 2'd1;
    localparam logic [1:0] S_PH_B = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // The counter is cleared on the driving edge, so the capture edge is the
    // one on which the count would step from SETTLE-1 to SETTLE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0]       state_q,  state_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [W_IN-1:0]  vec_q,    vec_d;
    logic [W_IN-1:0]  dut_x_q,  dut_x_d;
    logic [W_OUT-1:0] ya_q,     ya_d;
    logic [W_OUT-1:0] out_y_q,  out_y_d;
    logic [W_OUT-1:0] mask_q,   mask_d;
    logic             err_q,    err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] ecnt_q,   ecnt_d;

    logic             settle_hit;
    logic             inc_err;
    logic [W_OUT-1:0] mask_now;

    assign settle_hit = (cnt_q == SETTLE_LAST);
    assign mask_now   = ~(ya_q ^ dut_y_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        dut_x_d = dut_x_q;
        ya_d    = ya_q;
        out_y_d = out_y_q;
        mask_d  = mask_q;
        err_d   = err_q;
        inc_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    vec_d   = in_vec_i;
                    dut_x_d = in_vec_i;
                    cnt_d   = '0;
                    state_d = S_PH_A;
                end
            end
            S_PH_A: begin
                if (settle_hit) begin
                    ya_d    = dut_y_i;
                    dut_x_d = ~vec_q;
                    cnt_d   = '0;
                    state_d = S_PH_B;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_PH_B: begin
                if (settle_hit) begin
                    out_y_d = ya_q;
                    mask_d  = mask_now;
                    err_d   = |mask_now;
                    inc_err = |mask_now;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Error bookkeeping: clear wins over a coincident increment.
    always_comb begin
        ecnt_d   = ecnt_q;
        sticky_d = sticky_q;
        if (err_clr_i) begin
            ecnt_d   = '0;
            sticky_d = 1'b0;
        end else if (inc_err) begin
            sticky_d = 1'b1;
            if (ecnt_q != '1) begin
                ecnt_d = ecnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vec_q    <= '0;
            dut_x_q  <= '0;
            ya_q     <= '0;
            out_y_q  <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            dut_x_q  <= dut_x_d;
            ya_q     <= ya_d;
            out_y_q  <= out_y_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign in_ready_o   = (state_q == S_IDLE);
    assign out_valid_o  = (state_q == S_DONE);
    assign dut_x_o      = dut_x_q;
    assign out_y_o      = out_y_q;
    assign out_mask_o   = mask_q;
    assign out_err_o    = err_q;
    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = ecnt_q;

endmodule

// File: tb/tb_ctrl_sd_alt_checker.sv
// Scoreboard bench for ctrl_sd_alt_checker. The netlist is modelled as a
// selectable combinational function; expected results are computed by
// evaluating that function on v and ~v and pushed at accept time, then popped
// by an independent monitor whenever a result is presented.
module tb_ctrl_sd_alt_checker;

    localparam int WI = 33;
    localparam int WO = 26;
    localparam int S  = 3;
    localparam int CW = 3;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WI-1:0] in_vec;
    logic [WI-1:0] dut_x;
    logic [WO-1:0] dut_y;
    logic          out_valid;
    logic          out_ready;
    logic [WO-1:0] out_y;
    logic [WO-1:0] out_mask;
    logic          out_err;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;
    logic          err_clr;
    logic [1:0]    mode;

    always #5 clk = ~clk;

    ctrl_sd_alt_checker #(.W_IN(WI), .W_OUT(WO), .SETTLE(S), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_vec_i(in_vec),
        .dut_x_o(dut_x), .dut_y_i(dut_y),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_y_o(out_y), .out_mask_o(out_mask), .out_err_o(out_err),
        .err_sticky_o(err_sticky), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
    );

    // Netlist variants: 0 identity, 1 constant zero, 2 identity with y3 stuck
    // at 1, 3 a non-self-dual AND function with data-dependent violations.
    function automatic logic [WO-1:0] net(input logic [1:0] m, input logic [WI-1:0] x);
        case (m)
            2'd0:    net = x[WO-1:0];
            2'd1:    net = '0;
            2'd2:    net = x[WO-1:0] | 26'h0000008;
            default: net = x[WO-1:0] & x[WI-1:WI-WO];
        endcase
    endfunction

    always_comb dut_y = net(mode, dut_x);

    typedef struct {
        logic [WO-1:0] y;
        logic [WO-1:0] mask;
        logic          err;
        logic [CW-1:0] cnt;
        logic          sticky;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            passes = 0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_sticky = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [WI-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WI-1:0];
    endfunction

    // Monitor: one comparison set per presented result.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_y", out_y, e.y);
                    chk("out_mask", out_mask, e.mask);
                    chk("out_err", out_err, e.err);
                    chk("err_cnt", err_cnt, e.cnt);
                    chk("err_sticky", err_sticky, e.sticky);
                end
            end
        end
    end

    task automatic txn(input logic [WI-1:0] v, input logic [1:0] m, input int hold,
                       input bit early, input bit clr_same);
        exp_t          e;
        logic [WI-1:0] nv;
        int            k;
        nv     = ~v;
        mode   = m;
        e.y    = net(m, v);
        e.mask = ~(net(m, v) ^ net(m, nv));
        e.err  = |e.mask;
        if (clr_same) begin
            m_cnt    = '0;
            m_sticky = 1'b0;
        end else if (e.err) begin
            if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
            m_sticky = 1'b1;
        end
        e.cnt    = m_cnt;
        e.sticky = m_sticky;
        q.push_back(e);

        chk("in_ready_idle", in_ready, 1);
        in_vec    = v;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = rnd();
        chk("dut_x_phase_a", dut_x, v);
        k = 0;
        while (!out_valid && k < 64) begin
            @(posedge clk); #1;
            k++;
            if (k == S) chk("dut_x_phase_b", dut_x, nv);
            if (clr_same && k == 2*S-1) err_clr = 1'b1;
            if (k == 2*S) err_clr = 1'b0;
        end
        err_clr = 1'b0;
        chk("latency", k, 2*S);
        if (!early) begin
            in_valid = 1'b1;
            in_vec   = rnd();
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1);
                chk("hold_in_ready", in_ready, 0);
                chk("hold_y", out_y, e.y);
                chk("hold_mask", out_mask, e.mask);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
        chk("dut_x_kept", dut_x, nv);
        chk("cnt_after", err_cnt, m_cnt);
        chk("sticky_after", err_sticky, m_sticky);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        err_clr = 1'b0; mode = 2'd0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dut_x", dut_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_sticky", err_sticky, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        txn(33'h0_0000_00A5, 2'd0, 0, 1'b0, 1'b0);
        chk("identity_y", out_y, 26'h00000A5);
        txn('0, 2'd2, 1, 1'b0, 1'b0);
        chk("stuck_mask", out_mask, 26'h0000008);
        for (int i = 0; i < 10; i++) txn(rnd(), 2'd1, 0, 1'b1, 1'b0);
        chk("saturated", err_cnt, 3'd7);
        chk("const_mask", out_mask, 26'h3FFFFFF);
        txn(rnd(), 2'd0, 5, 1'b0, 1'b0);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr  = 1'b0;
        m_cnt    = '0;
        m_sticky = 1'b0;
        chk("clr_cnt", err_cnt, 0);
        chk("clr_sticky", err_sticky, 0);
        txn(rnd(), 2'd1, 0, 1'b0, 1'b0);
        chk("one_err", err_cnt, 1);
        txn(rnd(), 2'd1, 0, 1'b0, 1'b1);
        chk("clr_priority", err_cnt, 0);

        for (int i = 0; i < 40; i++)
            txn(rnd(), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b0);

        // Reset while in phase B: nothing must be reported.
        mode     = 2'd1;
        in_vec   = rnd();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (S + 1) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_cnt    = '0;
        m_sticky = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_dut_x", dut_x, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_cnt", err_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2 * S + 2) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", out_valid, 0);
        end
        txn(33'h1_2345_6789, 2'd0, 2, 1'b0, 1'b0);
        txn(33'h0_F0F0_F0F0, 2'd3, 0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sd_alt_checker.md
# ctrl_sd_alt_checker

Alternating-logic sequencer and checker for the self-dualized control netlists. Each accepted input vector goes to the combinational self-dual block twice: first true (phase A), then bitwise complemented (phase B). The block checks that every output bit inverts between the two phases, returns the phase-A output word with a per-bit mismatch mask, and keeps a saturating error count. It sits between the stimulus/host logic and the self-dual netlist; the netlist stays purely combinational.

## Interface
- W_IN, 33: width of the netlist input vector (x0..x32 packed, x0 = bit 0)
- W_OUT, 26: width of the netlist output vector (y0..y25 packed, y0 = bit 0)
- SETTLE, 1: cycles between driving dut_x and sampling dut_y; legal range 1..15
- CNT_W, 16: error counter width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request vector valid
- in_ready  out  1  block can accept a vector
- in_vec  in  W_IN  vector to check
- dut_x  out  W_IN  registered drive to the netlist inputs
- dut_y  in  W_OUT  netlist outputs (combinational from dut_x)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  W_OUT  dut_y sampled in phase A
- out_mask  out  W_OUT  1 where phase-A and phase-B bits are equal (self-duality violated)
- out_err  out  1  OR-reduction of out_mask
- err_sticky  out  1  set by any out_err, cleared only by reset or err_clr
- err_cnt  out  CNT_W  count of results with out_err=1, saturating at all-ones
- err_clr  in  1  synchronous clear of err_cnt and err_sticky

## Operation
- States: IDLE, PH_A, PH_B, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid & in_ready: latch in_vec into vec_q, set dut_x<=in_vec, clear the settle counter, go to PH_A.
- PH_A: counter increments each cycle. On the edge where the count reaches SETTLE: capture ya<=dut_y, set dut_x<=~vec_q, clear the counter, go to PH_B.
- PH_B: on the edge where the count reaches SETTLE: compute mask = ~(ya ^ dut_y); load out_y<=ya, out_mask, out_err; update the counter and sticky flag; go to DONE.
- DONE: out_valid=1, with out_y, out_mask and out_err held stable. On out_ready, go to IDLE. out_valid drops on that edge.
- in_ready=0 in PH_A, PH_B and DONE. in_valid is ignored there, so there is no overlap between transactions.
- dut_x keeps its last driven value (~vec_q) through DONE and IDLE until the next accept.
- err_cnt increments by 1 when the PH_B capture has out_err=1. When it is all-ones it stays all-ones.
- err_clr has priority: if err_clr and an increment fall on the same edge, err_cnt=0 and err_sticky=0 after the edge.
- err_clr does not affect the FSM or the result registers.

## Timing
- Reset (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, dut_x=0, out_y=0, out_mask=0, out_err=0, err_sticky=0, err_cnt=0. Any transaction in flight is discarded with no result.
- Accept edge E0: dut_x=vec from E0.
- Phase-A sample and switch to ~vec at edge E0+SETTLE.
- Phase-B sample at edge E0+2·SETTLE. out_valid is high in the following cycle.
- Accept-to-out_valid latency is 2·SETTLE edges; SETTLE=1 gives 2.
- Minimum accept-to-accept spacing is 2·SETTLE+2 cycles, reached when out_ready is held high.
- out_ready asserted while out_valid=0 has no effect.
- The netlist must settle within SETTLE cycles. dut_y is sampled only at the two capture edges.

## Test plan
- Identity loopback (dut_y=dut_x[25:0]), SETTLE=1, in_vec=0x0_0000_00A5 → out_valid 2 edges after accept, out_y=0x00000A5, out_mask=0, out_err=0, err_cnt stays 0.
- Constant netlist (dut_y=0) → out_mask=0x3FFFFFF, out_err=1, err_sticky=1, err_cnt=1. Ten back-to-back vectors → err_cnt=10.
- Single stuck bit (identity with y3 forced to 1), in_vec=0 → out_y bit3=1, out_mask=0x0000008, out_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is not accepted. Release → IDLE next cycle, then accept.
- CNT_W=2 with 5 erroring vectors → err_cnt saturates at 3. Assert err_clr on the same edge as the 6th increment → err_cnt=0, err_sticky=0.
- Deassert rst_n during PH_B → immediately out_valid=0, dut_x=0, in_ready=1, no result and no count change. SETTLE=3 run → accept-to-out_valid = 6 edges.
